// File: rtl/bcd_increment_arbiter_pkg.sv
// Shared definitions for the BCD display path: arbiter state encoding,
// default sizing and the grant-index width helper.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    localparam int DEFAULT_NUM_REQUESTERS   = 4;
    localparam int DEFAULT_PENDING_BITWIDTH = 4;

    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_GRANT_WIDTH = grant_width(DEFAULT_NUM_REQUESTERS);

endpackage

// File: rtl/bcd_increment_arbiter_round_robin_picker.sv
// Combinational round-robin search: first requester with pending work,
// starting at the pointer and wrapping modulo NUM_REQUESTERS.
module round_robin_picker
    import bcd_display_pkg::*;
#(
    parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS,
    parameter int ID_WIDTH       = grant_width(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] nonzero,
    input  logic [ID_WIDTH-1:0]       pointer,
    output logic [ID_WIDTH-1:0]       winner,
    output logic                      valid
);

    // One extra bit holds pointer+offset before the wrap back into range.
    logic [ID_WIDTH:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            idx = {1'b0, pointer} + (ID_WIDTH+1)'(i);
            if (idx >= (ID_WIDTH+1)'(NUM_REQUESTERS)) begin
                idx = idx - (ID_WIDTH+1)'(NUM_REQUESTERS);
            end
            if (!valid && nonzero[idx[ID_WIDTH-1:0]]) begin
                valid  = 1'b1;
                winner = idx[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/bcd_increment_arbiter.sv
// Queues increment pulses from several sources as saturating pending counts
// and feeds them one at a time into a shared BCD counter via enable/ready.
module bcd_increment_arbiter
    import bcd_display_pkg::*;
#(
    parameter int NUM_REQUESTERS   = DEFAULT_NUM_REQUESTERS,
    parameter int PENDING_BITWIDTH = DEFAULT_PENDING_BITWIDTH,
    parameter int ID_WIDTH         = grant_width(NUM_REQUESTERS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      clearOverflow,
    input  logic                      counterReady,
    output logic                      counterEnable,
    output logic                      grantValid,
    output logic [ID_WIDTH-1:0]       grantId,
    output logic [NUM_REQUESTERS-1:0] pendingOverflow,
    output logic                      busy
);

    localparam logic [PENDING_BITWIDTH-1:0] PEND_MAX = '1;
    localparam logic [PENDING_BITWIDTH-1:0] PEND_ONE = PENDING_BITWIDTH'(1);

    arb_state_t                  state;
    logic [PENDING_BITWIDTH-1:0] pending [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0]   nonzero;
    logic [NUM_REQUESTERS-1:0]   accept_vec;
    logic [NUM_REQUESTERS-1:0]   overflow_set;
    logic [ID_WIDTH-1:0]         pointer;
    logic [ID_WIDTH-1:0]         next_pointer;
    logic [ID_WIDTH-1:0]         winner;
    logic                        winner_valid;
    logic                        accept;

    round_robin_picker #(
        .NUM_REQUESTERS(NUM_REQUESTERS),
        .ID_WIDTH      (ID_WIDTH)
    ) picker (
        .nonzero(nonzero),
        .pointer(pointer),
        .winner (winner),
        .valid  (winner_valid)
    );

    // The counter has taken the enable once it drops ready while we are issuing.
    assign accept = (state == ISSUE) && !counterReady;
    assign busy   = (state != IDLE) || (|nonzero);

    always_comb begin
        nonzero      = '0;
        accept_vec   = '0;
        overflow_set = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            nonzero[i]      = (pending[i] != '0);
            accept_vec[i]   = accept && (grantId == ID_WIDTH'(i));
            overflow_set[i] = request[i] && !accept_vec[i] && (pending[i] == PEND_MAX);
        end
        if (grantId == ID_WIDTH'(NUM_REQUESTERS-1)) begin
            next_pointer = '0;
        end else begin
            next_pointer = grantId + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                pending[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (request[i] && !accept_vec[i] && (pending[i] != PEND_MAX)) begin
                    pending[i] <= pending[i] + PEND_ONE;
                end else if (!request[i] && accept_vec[i]) begin
                    pending[i] <= pending[i] - PEND_ONE;
                end
            end
        end
    end

    // A fresh overflow in the same cycle as a clear must stay visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pendingOverflow <= '0;
        end else begin
            pendingOverflow <= (clearOverflow ? '0 : pendingOverflow) | overflow_set;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            counterEnable <= 1'b0;
            grantValid    <= 1'b0;
            grantId       <= '0;
            pointer       <= '0;
        end else begin
            grantValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (winner_valid && counterReady) begin
                        grantId       <= winner;
                        counterEnable <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!counterReady) begin
                        counterEnable <= 1'b0;
                        grantValid    <= 1'b1;
                        pointer       <= next_pointer;
                        state         <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (counterReady) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_increment_arbiter.sv
// Directed bench for bcd_increment_arbiter with a behavioural 6-digit BCD
// counter that answers the enable/ready handshake.
module tb_bcd_increment_arbiter;

    localparam int PROC_CYCLES = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  request = '0;
    logic        clearOverflow = 1'b0;
    logic        counterReady;
    logic        counterEnable;
    logic        grantValid;
    logic [1:0]  grantId;
    logic [3:0]  pendingOverflow;
    logic        busy;

    logic [23:0] cnt_value;
    logic [23:0] preset_val = '0;
    logic        preset_go = 1'b0;
    logic        hold_busy = 1'b0;
    logic        armed;
    int          wait_cnt;
    int          inc_count;

    logic [1:0]  grant_q [$];
    int          checks = 0;
    int          failures = 0;

    bcd_increment_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .request        (request),
        .clearOverflow  (clearOverflow),
        .counterReady   (counterReady),
        .counterEnable  (counterEnable),
        .grantValid     (grantValid),
        .grantId        (grantId),
        .pendingOverflow(pendingOverflow),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        r = v;
        carry = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Counter model: increments once per armed enable, drops ready for a while,
    // and needs to see enable low before it will take the next one.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            counterReady <= 1'b0;
            cnt_value    <= '0;
            wait_cnt     <= 0;
            armed        <= 1'b1;
            inc_count    <= 0;
        end else begin
            if (preset_go) cnt_value <= preset_val;
            if (counterReady && counterEnable && armed) begin
                cnt_value    <= bcd_inc(cnt_value);
                inc_count    <= inc_count + 1;
                counterReady <= 1'b0;
                wait_cnt     <= PROC_CYCLES;
                armed        <= 1'b0;
            end else begin
                if (!counterReady) begin
                    if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
                    else if (!hold_busy) counterReady <= 1'b1;
                end
                if (!counterEnable) armed <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && grantValid) grant_q.push_back(grantId);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        request = '0;
        clearOverflow = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        grant_q.delete();
    endtask

    task automatic wait_idle(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            tick();
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (counterEnable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b want=0", counterEnable); end
        checks++; if (grantValid !== 1'b0) begin failures++; $display("FAIL reset_grantValid got=%b want=0", grantValid); end
        checks++; if (grantId !== 2'd0) begin failures++; $display("FAIL reset_grantId got=%0d want=0", grantId); end
        checks++; if (pendingOverflow !== 4'b0000) begin failures++; $display("FAIL reset_overflow got=%b want=0000", pendingOverflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_single();
        bit to;
        apply_reset();
        request = 4'b0100;
        tick();
        request = '0;
        checks++; if (counterEnable !== 1'b0) begin failures++; $display("FAIL single_enable_early got=%b want=0", counterEnable); end
        tick();
        checks++; if (counterEnable !== 1'b1) begin failures++; $display("FAIL single_enable_rise got=%b want=1", counterEnable); end
        wait_idle(60, to);
        checks++; if (to) begin failures++; $display("FAIL single_timeout got=busy want=idle"); end
        checks++; if (grant_q.size() != 1) begin failures++; $display("FAIL single_grants got=%0d want=1", grant_q.size()); end
        else begin
            checks++; if (grant_q[0] !== 2'd2) begin failures++; $display("FAIL single_grantId got=%0d want=2", grant_q[0]); end
        end
        checks++; if (cnt_value !== 24'h000001) begin failures++; $display("FAIL single_value got=%h want=000001", cnt_value); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b want=0", busy); end
    endtask

    task automatic test_all_four();
        logic [1:0] exp_order [4];
        logic       prev_en;
        int         rises;
        bit         to;
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3};
        apply_reset();
        request = 4'b1111;
        tick();
        request = '0;
        prev_en = counterEnable;
        rises = 0;
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (counterEnable && !prev_en) rises++;
            prev_en = counterEnable;
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        checks++; if (to) begin failures++; $display("FAIL four_timeout got=busy want=idle"); end
        checks++; if (grant_q.size() != 4) begin failures++; $display("FAIL four_grants got=%0d want=4", grant_q.size()); end
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            checks++; if (grant_q[i] !== exp_order[i]) begin failures++; $display("FAIL four_order[%0d] got=%0d want=%0d", i, grant_q[i], exp_order[i]); end
        end
        checks++; if (rises != 4) begin failures++; $display("FAIL four_enable_rises got=%0d want=4", rises); end
        checks++; if (cnt_value !== 24'h000004) begin failures++; $display("FAIL four_value got=%h want=000004", cnt_value); end
        checks++; if (inc_count != 4) begin failures++; $display("FAIL four_increments got=%0d want=4", inc_count); end
    endtask

    task automatic test_saturation();
        bit to;
        hold_busy = 1'b1;
        apply_reset();
        request = 4'b0001;
        for (int i = 0; i < 17; i++) tick();
        request = '0;
        tick();
        checks++; if (pendingOverflow !== 4'b0001) begin failures++; $display("FAIL sat_overflow got=%b want=0001", pendingOverflow); end
        checks++; if (dut.pending[0] !== 4'd15) begin failures++; $display("FAIL sat_pending got=%0d want=15", dut.pending[0]); end
        checks++; if (counterEnable !== 1'b0) begin failures++; $display("FAIL sat_enable got=%b want=0", counterEnable); end
        hold_busy = 1'b0;
        wait_idle(600, to);
        checks++; if (to) begin failures++; $display("FAIL sat_timeout got=busy want=idle"); end
        checks++; if (grant_q.size() != 15) begin failures++; $display("FAIL sat_grants got=%0d want=15", grant_q.size()); end
        checks++; if (cnt_value !== 24'h000015) begin failures++; $display("FAIL sat_value got=%h want=000015", cnt_value); end
        checks++; if (inc_count != 15) begin failures++; $display("FAIL sat_increments got=%0d want=15", inc_count); end
        checks++; if (pendingOverflow !== 4'b0001) begin failures++; $display("FAIL sat_overflow_sticky got=%b want=0001", pendingOverflow); end
        clearOverflow = 1'b1;
        tick();
        clearOverflow = 1'b0;
        checks++; if (pendingOverflow !== 4'b0000) begin failures++; $display("FAIL sat_clear got=%b want=0000", pendingOverflow); end
    endtask

    task automatic test_same_cycle();
        bit to;
        bit found;
        apply_reset();
        request = 4'b0010;
        tick();
        request = '0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (counterEnable && !counterReady) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL same_issue_timeout got=none want=issue"); end
        request = 4'b0010;
        tick();
        request = '0;
        checks++; if (grantValid !== 1'b1) begin failures++; $display("FAIL same_grantValid got=%b want=1", grantValid); end
        checks++; if (dut.pending[1] !== 4'd1) begin failures++; $display("FAIL same_pending got=%0d want=1", dut.pending[1]); end
        wait_idle(100, to);
        checks++; if (to) begin failures++; $display("FAIL same_timeout got=busy want=idle"); end
        checks++; if (grant_q.size() != 2) begin failures++; $display("FAIL same_grants got=%0d want=2", grant_q.size()); end
        for (int i = 0; i < 2 && i < grant_q.size(); i++) begin
            checks++; if (grant_q[i] !== 2'd1) begin failures++; $display("FAIL same_grantId[%0d] got=%0d want=1", i, grant_q[i]); end
        end
        checks++; if (cnt_value !== 24'h000002) begin failures++; $display("FAIL same_value got=%h want=000002", cnt_value); end
    endtask

    task automatic test_reset_midway();
        bit found;
        apply_reset();
        request = 4'b0111;
        tick();
        request = 4'b0001;
        tick();
        request = '0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (grantValid) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL midway_grant_timeout got=none want=grant"); end
        reset = 1'b1;
        #1;
        checks++; if (counterEnable !== 1'b0) begin failures++; $display("FAIL midway_enable got=%b want=0", counterEnable); end
        checks++; if (grantValid !== 1'b0) begin failures++; $display("FAIL midway_grantValid got=%b want=0", grantValid); end
        checks++; if (grantId !== 2'd0) begin failures++; $display("FAIL midway_grantId got=%0d want=0", grantId); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midway_busy got=%b want=0", busy); end
        tick();
        reset = 1'b0;
        grant_q.delete();
        for (int c = 0; c < 30; c++) tick();
        checks++; if (grant_q.size() != 0) begin failures++; $display("FAIL midway_stray_grants got=%0d want=0", grant_q.size()); end
        checks++; if (inc_count != 0) begin failures++; $display("FAIL midway_increments got=%0d want=0", inc_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midway_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_wrap();
        bit to;
        apply_reset();
        preset_val = 24'h999999;
        preset_go = 1'b1;
        tick();
        preset_go = 1'b0;
        request = 4'b0001;
        tick();
        request = '0;
        wait_idle(60, to);
        checks++; if (to) begin failures++; $display("FAIL wrap_timeout got=busy want=idle"); end
        checks++; if (cnt_value !== 24'h000000) begin failures++; $display("FAIL wrap_value got=%h want=000000", cnt_value); end
        checks++; if (grant_q.size() != 1) begin failures++; $display("FAIL wrap_grants got=%0d want=1", grant_q.size()); end
        checks++; if (counterEnable !== 1'b0) begin failures++; $display("FAIL wrap_enable got=%b want=0", counterEnable); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_saturation();
        test_same_cycle();
        test_reset_midway();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
